sha256_w_window_reader: RTL and testbench

Consumer end of the packed message-schedule window produced by the W-expansion pipeline stages. Accepts packed 7-word (224-bit) W windows on a valid/ready input and replays them to the compression-round datapath one 32-bit word per cycle, oldest word first. Holds two windows in ping-pong storage so a new window can load while the previous one drains, keeping the round datapath fed back-to-back.

---
 rtl/sha256_w_window_reader.sv | 102 ++++++++++
 tb/tb_sha256_w_window_reader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_w_window_reader.sv
// SHA-256 W window reader: ping-pong store of packed 7-word windows,
// replayed one word per cycle, oldest word first.
module sha256_w_window_reader #(
    parameter int WORDS = 7,
    parameter int WIDTH = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORDS*WIDTH-1:0] block_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       w_out,
    output logic [2:0]             w_idx,
    output logic                   w_last,
    output logic                   busy
);

    localparam int IDXW = 3;
    localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t                 state;
    logic [WORDS*WIDTH-1:0] slot [2];
    logic                   wr_sel;
    logic                   rd_sel;
    logic [IDXW-1:0]        idx;

    logic                   accept;
    logic                   xfer;
    logic                   retire;
    logic [WORDS*WIDTH-1:0] cur;
    logic [WIDTH-1:0]       word;

    // Ready/valid decode only from the registered state: no out_ready -> in_ready path.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign busy      = (state != EMPTY);

    assign accept = in_valid & in_ready;
    assign xfer   = out_valid & out_ready;
    assign retire = xfer & (idx == LAST);

    assign cur = slot[rd_sel];

    always_comb begin
        word = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (idx == IDXW'(k)) begin
                word = cur[(WORDS-k)*WIDTH-1 -: WIDTH];
            end
        end
    end

    assign w_out  = out_valid ? word : '0;
    assign w_idx  = out_valid ? idx : '0;
    assign w_last = out_valid & (idx == LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= EMPTY;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            idx     <= '0;
            slot[0] <= '0;
            slot[1] <= '0;
        end else begin
            if (accept) begin
                slot[wr_sel] <= block_in;
                wr_sel       <= ~wr_sel;
            end
            if (xfer) begin
                if (idx == LAST) begin
                    idx    <= '0;
                    rd_sel <= ~rd_sel;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            unique case (state)
                EMPTY: begin
                    if (accept) state <= ONE;
                end
                ONE: begin
                    if (accept && !retire) state <= FULL;
                    else if (!accept && retire) state <= EMPTY;
                end
                FULL: begin
                    if (retire) state <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_w_window_reader.sv
// Self-checking bench for sha256_w_window_reader against a queue-of-windows
// reference model.
module tb_sha256_w_window_reader;

    logic         CLK;
    logic         RST;
    logic         in_valid;
    logic         in_ready;
    logic [223:0] block_in;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  w_out;
    logic [2:0]   w_idx;
    logic         w_last;
    logic         busy;

    int n_checks;
    int n_fail;

    logic [223:0] mq[$];
    int           pos;

    logic [38:0] obs;
    logic [38:0] exp_v;

    sha256_w_window_reader dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .block_in  (block_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .w_out     (w_out),
        .w_idx     (w_idx),
        .w_last    (w_last),
        .busy      (busy)
    );

    assign obs = {in_ready, out_valid, w_out, w_idx, w_last, busy};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [223:0] mk(input logic [31:0] base);
        logic [223:0] b;
        b = '0;
        for (int k = 0; k < 7; k++) b[(7-k)*32-1 -: 32] = base + 32'(k + 1);
        return b;
    endfunction

    function automatic logic [223:0] rnd_win();
        logic [223:0] b;
        for (int k = 0; k < 7; k++) b[k*32 +: 32] = $urandom;
        return b;
    endfunction

    // Expected {in_ready,out_valid,w_out,w_idx,w_last,busy} from the model.
    function automatic logic [38:0] exp_vec();
        logic [223:0] t;
        logic [31:0]  w;
        logic         v;
        v = (mq.size() > 0);
        w = '0;
        if (v) begin
            t = mq[0];
            w = t[(7-pos)*32-1 -: 32];
        end
        return {(mq.size() < 2), v, w, v ? 3'(pos) : 3'd0, v && (pos == 6), v};
    endfunction

    task automatic advance();
        bit acc;
        bit xf;
        @(posedge CLK);
        acc = in_valid && (mq.size() < 2);
        xf  = out_ready && (mq.size() > 0);
        if (xf) begin
            pos++;
            if (pos == 7) begin
                void'(mq.pop_front());
                pos = 0;
            end
        end
        if (acc) mq.push_back(block_in);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        block_in = '0;
        mq.delete();
        pos = 0;
        repeat (2) @(negedge CLK);
        #1;
        n_checks++;
        if (obs !== 39'h40_0000_0000) begin
            n_fail++;
            $display("FAIL reset_state got=%h want=%h", obs, 39'h40_0000_0000);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_single();
        for (int c = 0; c < 10; c++) begin
            in_valid  = (c == 0);
            block_in  = (c == 0) ? mk(32'h0) * 0 + {32'h11111111, 32'h22222222,
                        32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666,
                        32'h77777777} : '0;
            out_ready = 1'b1;
            #1;
            exp_v = exp_vec();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL single c=%0d got=%h want=%h", c, obs, exp_v);
            end
            advance();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 18; c++) begin
            in_valid  = (c < 2);
            block_in  = (c == 0) ? mk(32'hA0000000 - 1) : mk(32'hB0000000 - 1);
            out_ready = 1'b1;
            #1;
            exp_v = exp_vec();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back c=%0d got=%h want=%h", c, obs, exp_v);
            end
            advance();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall();
        for (int c = 0; c < 18; c++) begin
            in_valid  = (c == 0);
            block_in  = mk(32'hC0000000 - 1);
            out_ready = (c % 2 == 0);
            #1;
            exp_v = exp_vec();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL stall c=%0d got=%h want=%h", c, obs, exp_v);
            end
            advance();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_retire();
        // A and B load, then C offered continuously while A drains.
        for (int c = 0; c < 24; c++) begin
            in_valid  = (c < 11);
            block_in  = (c == 0) ? mk(32'h10000000) :
                        (c == 1) ? mk(32'h20000000) : mk(32'h30000000);
            out_ready = (c >= 2);
            #1;
            exp_v = exp_vec();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL full_retire c=%0d got=%h want=%h", c, obs, exp_v);
            end
            advance();
        end
        in_valid = 1'b0;
        repeat (20) advance();
    endtask

    task automatic test_word6_value();
        logic [223:0] b;
        b = mk(32'h5000);
        b[31:0] = 32'h00A00055;
        for (int c = 0; c < 9; c++) begin
            in_valid  = (c == 0);
            block_in  = b;
            out_ready = 1'b1;
            #1;
            if (c == 7) begin
                n_checks++;
                if ({w_out, w_idx, w_last} !== {32'h00A00055, 3'd6, 1'b1}) begin
                    n_fail++;
                    $display("FAIL word6_value got=%h/%0d/%b want=00a00055/6/1",
                             w_out, w_idx, w_last);
                end
            end
            exp_v = exp_vec();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL word6 c=%0d got=%h want=%h", c, obs, exp_v);
            end
            advance();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        int guard;
        in_valid  = 1'b1;
        block_in  = mk(32'hD0000000);
        out_ready = 1'b0;
        advance();
        block_in  = mk(32'hE0000000);
        out_ready = 1'b1;
        advance();
        in_valid = 1'b0;
        guard = 0;
        while (pos != 3 && guard < 20) begin
            advance();
            guard++;
        end
        n_checks++;
        if (pos != 3 || w_idx !== 3'd3 || mq.size() != 2) begin
            n_fail++;
            $display("FAIL async_setup got idx=%0d want=3", w_idx);
        end
        #2;
        RST = 1'b1;
        #1;
        mq.delete();
        pos = 0;
        n_checks++;
        if (obs !== 39'h40_0000_0000) begin
            n_fail++;
            $display("FAIL async_reset got=%h want=%h", obs, 39'h40_0000_0000);
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < 9; c++) begin
            in_valid  = (c == 0);
            block_in  = mk(32'hF0000000);
            out_ready = 1'b1;
            #1;
            exp_v = exp_vec();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL after_reset c=%0d got=%h want=%h", c, obs, exp_v);
            end
            advance();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            block_in  = rnd_win();
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_v = exp_vec();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random c=%0d got=%h want=%h", c, obs, exp_v);
            end
            advance();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_full_retire();
        test_word6_value();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
